load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits directly upstream of DMEM in the RISC-V datapath, between the core's execute stage and the word-wide DMEM port (addr / dataW / dataR / MemRW).
- Accepts one load or store request at a time over a valid/ready handshake.
- Converts SB/SH into a word read-modify-write.
- Sign- or zero-extends load data.
- Returns a one-cycle response pulse.

Parameters:
MEM_BYTES, 4096, DMEM size in bytes; any access with req_addr >= MEM_BYTES is out of range.
- LSU_ST_W, 2, state register width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  core request valid
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data (rs2)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores
resp_err  output  1  access fault (misaligned / out-of-range / illegal funct3), valid with resp_valid
mem_addr  output  32  to DMEM addr, always word-aligned ({addr[31:2],2'b00})
mem_dataW  output  32  to DMEM dataW
mem_MemRW  output  1  to DMEM MemRW (1 = write)
mem_dataR  input  32  from DMEM dataR (combinational read)

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst).
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_dataW=0, mem_MemRW=0.
  - mem_MemRW drops immediately on rst assertion.
  - A write whose edge coincides with rst asserted is aborted.
- Handshake: transfer when req_valid && req_ready at a rising edge; request fields are latched then. req_ready=0 outside IDLE.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE + transfer:
    - fault -> RESP with err=1 (no DMEM access);
    - SW -> WRITE;
    - everything else -> READ.
  - READ: mem_MemRW=0; capture mem_dataR into rbuf at the edge.
    - Load -> RESP.
    - SB/SH -> WRITE.
  - WRITE: mem_MemRW=1 for exactly one cycle; mem_dataW = merged word.
    - SW: full req_wdata.
    - SH: rbuf with halfword lane addr[1] replaced by wdata[15:0].
    - SB: rbuf with byte lane addr[1:0] replaced by wdata[7:0].
    - Then -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE. req_ready rises in the following IDLE cycle; back-to-back requests are therefore spaced by one idle cycle minimum.
- Latency (accept edge to resp_valid high): load 2 cycles, SW 2, SB/SH 3, fault 1.
- Load extension, by funct3:
  - LB 000: sign-extend byte lane addr[1:0].
  - LH 001: sign-extend half lane addr[1].
  - LW 010: full word.
  - LBU 100: zero-extend byte lane.
  - LHU 101: zero-extend half lane.
- Store funct3: SB 000, SH 001, SW 010.
- Faults (with resp_err=1, resp_rdata=0, and no DMEM write):
  - any other funct3;
  - req_addr >= MEM_BYTES.
- mem_addr holds the latched aligned address in READ/WRITE and stays stable through RESP.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, is a fault (resp_err=1, no DMEM access, latency 1).
- Undefined: misalignment is not checked. Halfword uses lane addr[1] (addr[0] ignored); word ignores addr[1:0]. resp_err is then driven only by range/funct3 faults.

Decomposition:
- lsu_pkg:
  - state enum (IDLE/READ/WRITE/RESP);
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - byte-lane mask helper function.
- One combinational sub-module, lsu_align:
  - inputs: funct3, addr[1:0], rbuf, wdata;
  - outputs: merged store word and extended load data.
- All sequencing stays in load_store_unit.

Test Plan:
- SW addr=4, wdata=A5A5A5A5 -> mem_MemRW high exactly 1 cycle, mem_addr=4; resp_valid 2 cycles after accept; following LW addr=4 returns A5A5A5A5.
- Pre-store word 11223344 at addr 8; SB addr=9 wdata=000000EE -> READ then WRITE with mem_dataW=1122EE44; resp at 3 cycles.
- Word 80FF7F01 at addr 12:
  - LB addr=14 -> FFFFFFFF;
  - LBU addr=14 -> 000000FF;
  - LH addr=14 -> FFFF80FF;
  - LHU addr=12 -> 00007F01.
- LH addr=0x101:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1 at 1 cycle, mem_MemRW never high;
  - without: data from lane addr[1]=0, resp_err=0.
- Fault cases:
  - SW addr=4096 -> resp_err=1, no write;
  - funct3=011 load -> resp_err=1.
- Assert rst during SB's WRITE state -> mem_MemRW=0 immediately; memory word unchanged; state IDLE, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and lane helper for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned LSU_ST_W = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [LSU_ST_W-1:0] {
    IDLE  = LSU_ST_W'(0),
    READ  = LSU_ST_W'(1),
    WRITE = LSU_ST_W'(2),
    RESP  = LSU_ST_W'(3)
  } lsuStateT;

  // Request fields held for the duration of one access.
  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [1:0]      addrLo;
    logic [XLEN-1:0] wdata;
  } lsuReqT;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] laneMask(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic [3:0] m;
    m = 4'b0000;
    case (funct3[1:0])
      2'b00:   m = 4'b0001 << addrLo;
      2'b01:   m = addrLo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: merges store data into a read word and extends load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addrLo,
  input  logic [XLEN-1:0] rbuf,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] storeWord_c,
  output logic [XLEN-1:0] loadData_c
);

  logic [3:0]      mask;
  logic [XLEN-1:0] wdataRep;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;

  // Replicate store data across lanes, then keep only the masked lanes.
  always_comb begin
    mask        = laneMask(funct3, addrLo);
    wdataRep    = wdata;
    storeWord_c = rbuf;
    case (funct3[1:0])
      2'b00:   wdataRep = {4{wdata[7:0]}};
      2'b01:   wdataRep = {2{wdata[15:0]}};
      default: wdataRep = wdata;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) storeWord_c[8*i +: 8] = wdataRep[8*i +: 8];
    end
  end

  // Select the addressed lane and sign/zero extend; halfword ignores addrLo[0].
  always_comb begin
    byteSel    = rbuf[{addrLo, 3'b000} +: 8];
    halfSel    = rbuf[{addrLo[1], 4'b0000} +: 16];
    loadData_c = rbuf;
    case (funct3)
      F3_B:    loadData_c = {{24{byteSel[7]}}, byteSel};
      F3_H:    loadData_c = {{16{halfSel[15]}}, halfSel};
      F3_BU:   loadData_c = {24'h000000, byteSel};
      F3_HU:   loadData_c = {16'h0000, halfSel};
      default: loadData_c = rbuf;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide DMEM port: one access at a time,
// sub-word stores done as read-modify-write, one-cycle response pulse.
// Optional misalignment faults are enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_dataW,
  output logic            mem_MemRW,
  input  logic [XLEN-1:0] mem_dataR
);

  lsuStateT        stateQ, stateNext;
  lsuReqT          reqQ;
  logic            accept;
  logic            f3Illegal, outOfRange, misaligned, reqFault;
  logic [XLEN-1:0] storeWord, loadData;

  logic            readyNext, respValidNext, respErrNext, memRWNext;
  logic [XLEN-1:0] respRdataNext, memAddrNext, memDataWNext;

  // Classify the incoming request before it is accepted.
  always_comb begin
    accept     = req_valid && req_ready;
    outOfRange = req_addr >= XLEN'(MEM_BYTES);
    if (req_we) begin
      f3Illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      f3Illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
               || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    reqFault = f3Illegal || outOfRange || misaligned;
  end

  // The word being read is merged/extended on the same edge it is captured.
  lsu_align uAlign (
    .funct3      (reqQ.funct3),
    .addrLo      (reqQ.addrLo),
    .rbuf        (mem_dataR),
    .wdata       (reqQ.wdata),
    .storeWord_c (storeWord),
    .loadData_c  (loadData)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    stateNext     = stateQ;
    readyNext     = 1'b0;
    respValidNext = 1'b0;
    respErrNext   = 1'b0;
    respRdataNext = '0;
    memRWNext     = 1'b0;
    memAddrNext   = mem_addr;
    memDataWNext  = mem_dataW;
    case (stateQ)
      IDLE: begin
        readyNext = 1'b1;
        if (accept) begin
          readyNext = 1'b0;
          if (reqFault) begin
            stateNext     = RESP;
            respValidNext = 1'b1;
            respErrNext   = 1'b1;
          end else if (req_we && req_funct3 == F3_W) begin
            stateNext    = WRITE;
            memRWNext    = 1'b1;
            memAddrNext  = {req_addr[XLEN-1:2], 2'b00};
            memDataWNext = req_wdata;
          end else begin
            stateNext   = READ;
            memAddrNext = {req_addr[XLEN-1:2], 2'b00};
          end
        end
      end
      READ: begin
        if (reqQ.we) begin
          stateNext    = WRITE;
          memRWNext    = 1'b1;
          memDataWNext = storeWord;
        end else begin
          stateNext     = RESP;
          respValidNext = 1'b1;
          respRdataNext = loadData;
        end
      end
      WRITE: begin
        stateNext     = RESP;
        respValidNext = 1'b1;
      end
      RESP: begin
        stateNext = IDLE;
        readyNext = 1'b1;
      end
      default: begin
        stateNext = IDLE;
        readyNext = 1'b1;
      end
    endcase
  end

  // State, latched request and output registers; reset aborts any write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= IDLE;
      reqQ       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_dataW  <= '0;
      mem_MemRW  <= 1'b0;
    end else begin
      stateQ     <= stateNext;
      req_ready  <= readyNext;
      resp_valid <= respValidNext;
      resp_rdata <= respRdataNext;
      resp_err   <= respErrNext;
      mem_addr   <= memAddrNext;
      mem_dataW  <= memDataWNext;
      mem_MemRW  <= memRWNext;
      if (accept) begin
        reqQ.we     <= req_we;
        reqQ.funct3 <= req_funct3;
        reqQ.addrLo <= req_addr[1:0];
        reqQ.wdata  <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word-wide DMEM.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataW;
  logic        mem_MemRW;
  logic [31:0] mem_dataR;

  logic [31:0] mem [0:1023];

  int nCmp;
  int nErr;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_dataW  (mem_dataW),
    .mem_MemRW  (mem_MemRW),
    .mem_dataR  (mem_dataR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM: combinational read, write on rising edge when MemRW is high.
  assign mem_dataR = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_MemRW) mem[mem_addr[11:2]] <= mem_dataW;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expWrites;
    logic [31:0] expDataW;
  } vecT;

  vecT vecs[$];

  function automatic vecT mkVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expRdata,
                                input logic expErr, input int expLat, input int expWrites,
                                input logic [31:0] expDataW);
    vecT v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.expRdata = expRdata;
    v.expErr = expErr; v.expLat = expLat; v.expWrites = expWrites; v.expDataW = expDataW;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeoutFail(input string nm);
    nCmp++;
    nErr++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Issue one request and follow it to its response pulse.
  task automatic doReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                       output int lat, output int writes, output logic [31:0] lastDataW,
                       output logic [31:0] lastAddr, output logic ok);
    int n;
    ok = 1'b1; writes = 0; lat = 0; rdata = '0; err = 1'b0;
    lastDataW = '0; lastAddr = '0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      ok = 1'b0;
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (1) begin
      if (mem_MemRW) begin
        writes++;
        lastDataW = mem_dataW;
        lastAddr  = mem_addr;
      end
      if (resp_valid) begin
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
      if (lat >= 10) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    logic [31:0] rdata, lastDataW, lastAddr;
    logic        err, ok;
    int          lat, writes, n;
    logic [31:0] wordAddr;

    nCmp = 0; nErr = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;

    mem[2]    <= 32'h11223344;
    mem[3]    <= 32'h80FF7F01;
    mem[5]    <= 32'h12345678;
    mem[64]   <= 32'h00008123;
    mem[1023] <= 32'hDEADBEEF;

    vecs.push_back(mkVec(1'b1, 3'b010, 32'd4,    32'hA5A5A5A5, 32'h0,        1'b0, 2, 1, 32'hA5A5A5A5));
    vecs.push_back(mkVec(1'b0, 3'b010, 32'd4,    32'h0,        32'hA5A5A5A5, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mkVec(1'b1, 3'b000, 32'd9,    32'h000000EE, 32'h0,        1'b0, 3, 1, 32'h1122EE44));
    vecs.push_back(mkVec(1'b1, 3'b001, 32'd10,   32'h0000BEEF, 32'h0,        1'b0, 3, 1, 32'hBEEFEE44));
    vecs.push_back(mkVec(1'b0, 3'b010, 32'd8,    32'h0,        32'hBEEFEE44, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b000, 32'd14,   32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b100, 32'd14,   32'h0,        32'h000000FF, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b001, 32'd14,   32'h0,        32'hFFFF80FF, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b101, 32'd12,   32'h0,        32'h00007F01, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b000, 32'd13,   32'h0,        32'h0000007F, 1'b0, 2, 0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h101,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0));
`else
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h101,  32'h0,        32'hFFFF8123, 1'b0, 2, 0, 32'h0));
`endif
    vecs.push_back(mkVec(1'b1, 3'b010, 32'd4096, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b011, 32'd0,    32'h0,        32'h0,        1'b1, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b1, 3'b100, 32'd0,    32'h0,        32'h0,        1'b1, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b010, 32'd4092, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'b100, 32'hFFFFFFFF, 32'h0,    32'h0,        1'b1, 1, 0, 32'h0));

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready",  32'(req_ready),  32'h1);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst resp_rdata", resp_rdata,      32'h0);
    chk("rst resp_err",   32'(resp_err),   32'h0);
    chk("rst mem_addr",   mem_addr,        32'h0);
    chk("rst mem_dataW",  mem_dataW,       32'h0);
    chk("rst mem_MemRW",  32'(mem_MemRW),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven transactions.
    for (int i = 0; i < vecs.size(); i++) begin
      doReq(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
            rdata, err, lat, writes, lastDataW, lastAddr, ok);
      if (!ok) begin
        timeoutFail($sformatf("vec%0d", i));
        continue;
      end
      chk($sformatf("vec%0d rdata", i),  rdata,       vecs[i].expRdata);
      chk($sformatf("vec%0d err", i),    32'(err),    32'(vecs[i].expErr));
      chk($sformatf("vec%0d latency", i), 32'(lat),   32'(vecs[i].expLat));
      chk($sformatf("vec%0d writes", i), 32'(writes), 32'(vecs[i].expWrites));
      if (vecs[i].expWrites > 0) begin
        wordAddr = {vecs[i].addr[31:2], 2'b00};
        chk($sformatf("vec%0d dataW", i),   lastDataW, vecs[i].expDataW);
        chk($sformatf("vec%0d memAddr", i), lastAddr,  wordAddr);
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pulse", i), 32'(resp_valid), 32'h0);
      chk($sformatf("vec%0d mem_MemRW idle", i), 32'(mem_MemRW), 32'h0);
      if (vecs[i].expWrites > 0) begin
        chk($sformatf("vec%0d memWord", i), mem[vecs[i].addr[11:2]], vecs[i].expDataW);
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'h1);
    end

    // Reset asserted while an SB sits in WRITE: write must be dropped.
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'd20; req_wdata = 32'h000000FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_MemRW && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!mem_MemRW) begin
      timeoutFail("rstWrite reach WRITE");
    end else begin
      chk("rstWrite dataW", mem_dataW, 32'h123456FF);
      #2;
      rst = 1'b1;
      #1;
      chk("rstWrite MemRW drop", 32'(mem_MemRW), 32'h0);
    end
    @(posedge clk);
    #1;
    chk("rstWrite ready in rst", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstWrite memWord", mem[5], 32'h12345678);
    chk("rstWrite ready",   32'(req_ready),  32'h1);
    chk("rstWrite resp",    32'(resp_valid), 32'h0);
    chk("rstWrite mem_addr", mem_addr,       32'h0);

    // Normal operation after the aborted write.
    doReq(1'b0, 3'b010, 32'd20, 32'h0, rdata, err, lat, writes, lastDataW, lastAddr, ok);
    if (!ok) begin
      timeoutFail("postRst LW");
    end else begin
      chk("postRst LW rdata",   rdata,    32'h12345678);
      chk("postRst LW err",     32'(err), 32'h0);
      chk("postRst LW latency", 32'(lat), 32'h2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
